freqmeter_fsslice: RTL
======================

Name: freqmeter_fsslice

Overview:
- Measured-clock-domain counting slice for the clock-frequency measurement subsystem; one instance per monitored clock.
- The reference-domain controller drives a level gate window and a return acknowledge toggle. Both arrive asynchronously.
- The slice synchronizes the gate, counts clkin cycles while the gate is open, and prescales the result.
- It publishes the result to the reference domain with a req/ack toggle handshake. The data stays stable until the next publish.

Parameters:
- FW, 16: published count width.
- PRESHIFT, 2: prescale shift; the published value is the raw count >> PRESHIFT.
- SYNCW, 2: synchronizer depth for gate and ack_tog (minimum 2).

Ports:
- clkin  input  1  measured clock; all logic runs on this clock.
- fsresetn  input  1  asynchronous, active-low reset.
- gate  input  1  async level from reference domain; 1 = measurement window open.
- ack_tog  input  1  async toggle from reference domain; it equals req_tog once the result has been consumed.
- req_tog  output  1  toggles once per published result.
- cnt_out  output  FW  published prescaled count.
- ovf_out  output  1  published count saturated.
- miss_out  output  1  at least one window was skipped since the previous publish.

Behaviour:
- Reset (async assert, sync release by the system):
  - All sync flops = 0.
  - state = IDLE; cnt = 0; req_tog = 0; cnt_out = 0; ovf_out = 0; miss_out = 0; sat = 0; miss_sticky = 0.
- Synchronization:
  - gate_s is gate after SYNCW flops; gate_d is gate_s delayed one cycle.
  - rise = gate_s & ~gate_d; fall = ~gate_s & gate_d.
  - ack_s is ack_tog after SYNCW flops.
  - Pulses shorter than a clkin period may be lost; this is acceptable.
- Raw counter: cnt is FW+PRESHIFT bits.
- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - On rise: cnt <= 1, sat <= 0, go to COUNT.
  - A fall in IDLE is ignored.
- COUNT:
  - Each cycle with gate_s = 1: cnt <= cnt + 1, saturating at all-ones. Reaching all-ones sets sat.
  - On fall (cnt is not incremented in this cycle):
    - cnt_out <= cnt[FW+PRESHIFT-1:PRESHIFT] (truncating shift).
    - ovf_out <= sat; miss_out <= miss_sticky; miss_sticky <= 0.
    - req_tog <= ~req_tog; go to HOLD.
  - Result: cnt_out = floor(N / 2^PRESHIFT), where N = number of cycles gate_s was high.
- HOLD:
  - Go to IDLE when ack_s == req_tog.
  - A rise while in HOLD sets miss_sticky. That window is discarded; it is not counted later.
  - A rise and the ack match in the same cycle: HOLD wins, the window is missed, and the FSM goes to IDLE.
  - Leaving HOLD while gate_s is still high waits for the next genuine rise.
- Latency:
  - rise is seen SYNCW+1 clkin cycles after gate goes high.
  - req_tog changes on the cycle after fall is detected.
- Stability: cnt_out, ovf_out and miss_out change only in the same cycle that req_tog toggles. They are constant at all other times, so the reference domain may sample them after synchronizing req_tog.
- Reset mid-operation: the partial count is discarded and all outputs drop to reset values immediately. The handshake restarts from req_tog = 0, so the reference domain must also be reset.
- No X propagation: all flops are reset, and no output is combinational from an async input.

Test Plan:
- Defaults. Gate_s held high for 100 clkin cycles, ack returned 5 cycles after req_tog -> req_tog toggles once, cnt_out = 25, ovf_out = 0, miss_out = 0, FSM returns to IDLE.
- Gate_s held high for 103 cycles -> cnt_out = 25 (truncation). Gate_s held high for 1 cycle -> cnt_out = 0 and req_tog still toggles.
- FW = 8, PRESHIFT = 2. Gate_s held high for 1100 cycles -> raw count saturates at 1023, cnt_out = 255, ovf_out = 1. The next 40-cycle window -> cnt_out = 10, ovf_out = 0.
- Ack withheld after the first result (cnt_out = 25); a second 60-cycle gate pulse is applied -> no req_tog toggle, cnt_out stays 25. Then ack is returned, followed by a 40-cycle pulse -> cnt_out = 10, miss_out = 1. A further 40-cycle pulse -> miss_out = 0.
- fsresetn pulsed low 50 cycles into COUNT -> req_tog, cnt_out, ovf_out and miss_out all read 0 within the same timestep. After release, a new 8-cycle window -> cnt_out = 2.
- Rise coincident with ack match in HOLD -> miss_sticky set, no new count started; the next clean 20-cycle window -> cnt_out = 5, miss_out = 1.

Source files
------------

// File: rtl/freqmeter_fsslice.sv
// Measured-clock-domain counting slice of the frequency meter.
// Counts clkin cycles while the synchronized gate window is open, prescales
// the count and publishes it to the reference domain with a req/ack toggle.
module freqmeter_fsslice #(
    parameter int unsigned FW       = 16,
    parameter int unsigned PRESHIFT = 2,
    parameter int unsigned SYNCW    = 2
) (
    input  logic          clkin,
    input  logic          fsresetn,
    input  logic          gate,
    input  logic          ack_tog,
    output logic          req_tog,
    output logic [FW-1:0] cnt_out,
    output logic          ovf_out,
    output logic          miss_out
);

    localparam int unsigned CW = FW + PRESHIFT;
    localparam logic [CW-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

    logic [SYNCW-1:0] gate_sync, ack_sync;
    logic             gate_s, gate_d, ack_s;
    logic             rise, fall;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             miss_sticky_q, miss_sticky_d;
    logic             req_q, req_d;
    logic [FW-1:0]    cnt_out_q, cnt_out_d;
    logic             ovf_q, ovf_d;
    logic             miss_q, miss_d;

    assign gate_s = gate_sync[SYNCW-1];
    assign ack_s  = ack_sync[SYNCW-1];
    assign rise   = gate_s & ~gate_d;
    assign fall   = ~gate_s & gate_d;

    // Bring gate and ack_tog into the clkin domain; keep one extra gate stage for edges.
    always_ff @(posedge clkin or negedge fsresetn) begin
        if (!fsresetn) begin
            gate_sync <= '0;
            ack_sync  <= '0;
            gate_d    <= 1'b0;
        end else begin
            gate_sync <= {gate_sync[SYNCW-2:0], gate};
            ack_sync  <= {ack_sync[SYNCW-2:0], ack_tog};
            gate_d    <= gate_s;
        end
    end

    // State register for the FSM, raw counter and published result.
    always_ff @(posedge clkin or negedge fsresetn) begin
        if (!fsresetn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            sat_q         <= 1'b0;
            miss_sticky_q <= 1'b0;
            req_q         <= 1'b0;
            cnt_out_q     <= '0;
            ovf_q         <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sat_q         <= sat_d;
            miss_sticky_q <= miss_sticky_d;
            req_q         <= req_d;
            cnt_out_q     <= cnt_out_d;
            ovf_q         <= ovf_d;
            miss_q        <= miss_d;
        end
    end

    // Next-state logic: open a window on rise, count, publish on fall, wait for ack.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sat_d         = sat_q;
        miss_sticky_d = miss_sticky_q;
        req_d         = req_q;
        cnt_out_d     = cnt_out_q;
        ovf_d         = ovf_q;
        miss_d        = miss_q;
        unique case (state_q)
            StIdle: begin
                // A stale fall here is ignored; only a genuine rise opens a window.
                if (rise) begin
                    cnt_d   = CW'(1);
                    sat_d   = 1'b0;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (fall) begin
                    cnt_out_d     = cnt_q[CW-1:PRESHIFT];
                    ovf_d         = sat_q;
                    miss_d        = miss_sticky_q;
                    miss_sticky_d = 1'b0;
                    req_d         = ~req_q;
                    state_d       = StHold;
                end else if (gate_s) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    sat_d = sat_q | (cnt_d == CntMax);
                end
            end
            StHold: begin
                // A window opening while the result is unconsumed is dropped, even
                // if the ack lands in the very same cycle.
                if (rise) begin
                    miss_sticky_d = 1'b1;
                end
                if (ack_s == req_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_tog  = req_q;
    assign cnt_out  = cnt_out_q;
    assign ovf_out  = ovf_q;
    assign miss_out = miss_q;

endmodule
